// File: rtl/mix_tty_tx.sv
// MIX typewriter output stage: splits 30-bit MIX words into five 6-bit character codes and sends them as UART 8N1.
// Optional CR LF after every WORDS_PER_LINE words when MIX_TTY_CRLF_EN is defined.
module mix_tty_tx #(
    parameter int CLK_DIV        = 104,
    parameter int WORDS_PER_LINE = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [29:0] in_data,
    output logic        tx,
    output logic        busy
);

    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (CLK_DIV < 2 || WORDS_PER_LINE < 1) begin : g_bad_param
        $error("mix_tty_tx: CLK_DIV must be >= 2 and WORDS_PER_LINE >= 1");
    end

`ifdef MIX_TTY_CRLF_EN
    localparam int WCW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, EOL} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state;
    logic [29:0]   word;
    logic [7:0]    shreg;
    logic [2:0]    char_idx;
    logic [2:0]    bit_idx;
    logic [BW-1:0] baud_cnt;
    logic          baud_wrap;

`ifdef MIX_TTY_CRLF_EN
    logic [WCW-1:0] word_cnt;
    logic [3:0]     eol_bit;
    logic           eol_lf;
    logic [8:0]     eol_frame;
`endif

    function automatic logic [5:0] char_at(input logic [29:0] w, input logic [2:0] idx);
        case (idx)
            3'd0:    char_at = w[29:24];
            3'd1:    char_at = w[23:18];
            3'd2:    char_at = w[17:12];
            3'd3:    char_at = w[11:6];
            default: char_at = w[5:0];
        endcase
    endfunction

    // MIX typewriter code to ASCII; the letter runs are contiguous, so they are offsets.
    function automatic logic [7:0] ascii(input logic [5:0] code);
        logic [7:0] c8;
        c8 = {2'b00, code};
        if (code == 6'd0)        ascii = 8'h20;
        else if (code <= 6'd9)   ascii = c8 + 8'h40;
        else if (code == 6'd10)  ascii = 8'h7E;
        else if (code <= 6'd19)  ascii = c8 + 8'h3F;
        else if (code == 6'd20)  ascii = 8'h5B;
        else if (code == 6'd21)  ascii = 8'h5D;
        else if (code <= 6'd29)  ascii = c8 + 8'h3D;
        else if (code <= 6'd39)  ascii = c8 + 8'h12;
        else begin
            // NOTE: every path assigns the result; a case without default here would infer a latch in comb use.
            case (code)
                6'd40:   ascii = 8'h2E;
                6'd41:   ascii = 8'h2C;
                6'd42:   ascii = 8'h28;
                6'd43:   ascii = 8'h29;
                6'd44:   ascii = 8'h2B;
                6'd45:   ascii = 8'h2D;
                6'd46:   ascii = 8'h2A;
                6'd47:   ascii = 8'h2F;
                6'd48:   ascii = 8'h3D;
                6'd49:   ascii = 8'h24;
                6'd50:   ascii = 8'h3C;
                6'd51:   ascii = 8'h3E;
                6'd52:   ascii = 8'h40;
                6'd53:   ascii = 8'h3B;
                6'd54:   ascii = 8'h3A;
                6'd55:   ascii = 8'h27;
                default: ascii = 8'h3F;
            endcase
        end
    endfunction

    assign baud_wrap = (baud_cnt == BW'(CLK_DIV - 1));
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            word     <= '0;
            shreg    <= '0;
            char_idx <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
`ifdef MIX_TTY_CRLF_EN
            word_cnt  <= '0;
            eol_bit   <= '0;
            eol_lf    <= 1'b0;
            eol_frame <= '0;
`endif
        end else begin
            if (state == IDLE || baud_wrap) baud_cnt <= '0;
            else                            baud_cnt <= baud_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word     <= in_data;
                        char_idx <= '0;
                        bit_idx  <= '0;
                        shreg    <= ascii(in_data[29:24]);
                        tx       <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_wrap) begin
                        tx      <= shreg[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[bit_idx + 3'd1];
                        end
                    end
                end
                STOP: begin
                    if (baud_wrap) begin
                        if (char_idx < 3'd4) begin
                            char_idx <= char_idx + 3'd1;
                            shreg    <= ascii(char_at(word, char_idx + 3'd1));
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
`ifdef MIX_TTY_CRLF_EN
                            if (word_cnt == WCW'(WORDS_PER_LINE - 1)) begin
                                word_cnt  <= '0;
                                eol_bit   <= '0;
                                eol_lf    <= 1'b0;
                                eol_frame <= {1'b1, 8'h0D};
                                tx        <= 1'b0;
                                state     <= EOL;
                            end else begin
                                word_cnt <= word_cnt + 1'b1;
                                state    <= IDLE;
                            end
`else
                            state <= IDLE;
`endif
                        end
                    end
                end
`ifdef MIX_TTY_CRLF_EN
                // eol_frame holds the remaining data+stop bits of the CR or LF frame on tx.
                EOL: begin
                    if (baud_wrap) begin
                        if (eol_bit == 4'd9) begin
                            if (!eol_lf) begin
                                eol_lf    <= 1'b1;
                                eol_bit   <= '0;
                                eol_frame <= {1'b1, 8'h0A};
                                tx        <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            tx        <= eol_frame[0];
                            eol_frame <= {1'b0, eol_frame[8:1]};
                            eol_bit   <= eol_bit + 4'd1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_tty_tx.sv
// Directed self-checking bench for mix_tty_tx (CLK_DIV=4, WORDS_PER_LINE=2); follows MIX_TTY_CRLF_EN if defined.
module tb_mix_tty_tx;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [29:0] in_data;
    logic        tx;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    // MIX code -> ASCII reference, written out as the typewriter character set.
    string cmap = " ABCDEFGHI~JKLMNOPQR[]STUVWXYZ0123456789.,()+-*/=$<>@;:'????????";

    mix_tty_tx #(.CLK_DIV(4), .WORDS_PER_LINE(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] mk(input int c0, input int c1, input int c2, input int c3, input int c4);
        return {6'(c0), 6'(c1), 6'(c2), 6'(c3), 6'(c4)};
    endfunction

    function automatic logic [7:0] exp_char(input logic [29:0] w, input int k);
        logic [5:0] code;
        code = w[29-6*k -: 6];
        return cmap[int'(code)];
    endfunction

    function automatic logic [29:0] pattern(input int c);
        return mk(c, c + 1, c + 2, c + 3, c + 4);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Present a word when ready; returns 1 ns after the accepting edge.
    task automatic send_word(input logic [29:0] w);
        int n = 0;
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Sample one 8N1 frame mid-bit; the first tx=0 negedge is the first start-bit cycle.
    task automatic rx_byte(output logic [7:0] b);
        int n = 0;
        b = '0;
        do begin
            @(negedge clk);
            n++;
        end while (tx !== 1'b0 && n < 3000);
        check("rx_start_seen", tx, 1'b0);
        repeat (2) @(negedge clk);
        check("rx_start_mid", tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            b[i] = tx;
        end
        repeat (4) @(negedge clk);
        check("rx_stop", tx, 1'b1);
    endtask

    task automatic rx_word(input logic [29:0] w, input string tag);
        logic [7:0] b;
        for (int k = 0; k < 5; k++) begin
            rx_byte(b);
            check($sformatf("%s_c%0d", tag, k), b, exp_char(w, k));
        end
    endtask

    task automatic rx_eol(input string tag);
        logic [7:0] b;
`ifdef MIX_TTY_CRLF_EN
        rx_byte(b);
        check({tag, "_cr"}, b, 8'h0D);
        rx_byte(b);
        check({tag, "_lf"}, b, 8'h0A);
`else
        b = '0;
`endif
    endtask

    initial begin
        logic [29:0] w_hello, w_a, w_b, w1, w2, w3, w_rst, w_new;
        logic [39:0] got_frame, exp_frame;
        logic [9:0]  fb;
        logic [7:0]  b;
        int          cnt, busy_bad;

        clk      = 1'b0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        w_hello  = mk(8, 5, 13, 13, 16);
        w_a      = mk(30, 39, 0, 63, 55);
        w_b      = mk(10, 20, 21, 40, 54);
        w1       = mk(1, 2, 3, 4, 5);
        w2       = mk(22, 29, 41, 47, 52);
        w3       = mk(11, 19, 44, 45, 49);
        w_rst    = mk(1, 2, 4, 5, 6);
        w_new    = mk(30, 31, 32, 33, 34);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_tx", tx, 1'b1);
        check("rst_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);

        // HELLO with explicit ASCII expectations
        send_word(w_hello);
        check("accept_ready_drop", in_ready, 1'b0);
        rx_byte(b); check("hello_H", b, 8'h48);
        rx_byte(b); check("hello_E", b, 8'h45);
        rx_byte(b); check("hello_L1", b, 8'h4C);
        rx_byte(b); check("hello_L2", b, 8'h4C);
        rx_byte(b); check("hello_O", b, 8'h4F);

        // Frame shape and word duration: 200 busy cycles from the first start bit
        do_reset();
        send_word(w_hello);
        fb = {1'b1, 8'h48, 1'b0};
        for (int i = 0; i < 40; i++) exp_frame[i] = fb[i / 4];
        got_frame = '0;
        cnt       = 0;
        busy_bad  = 0;
        @(negedge clk);
        while (!in_ready && cnt < 2000) begin
            if (cnt < 40) got_frame[cnt] = tx;
            if (busy !== 1'b1) busy_bad++;
            cnt++;
            @(negedge clk);
        end
        check("frame_bits", got_frame, exp_frame);
        check("word_cycles", cnt, 200);
        check("busy_throughout", busy_bad, 0);
        check("idle_busy", busy, 1'b0);
        check("idle_tx", tx, 1'b1);

        // Digits, space, '?', apostrophe and the punctuation codes
        do_reset();
        send_word(w_a);
        rx_byte(b); check("t3_0", b, 8'h30);
        rx_byte(b); check("t3_9", b, 8'h39);
        rx_byte(b); check("t3_sp", b, 8'h20);
        rx_byte(b); check("t3_q", b, 8'h3F);
        rx_byte(b); check("t3_ap", b, 8'h27);
        send_word(w_b);
        rx_byte(b); check("t3_tilde", b, 8'h7E);
        rx_byte(b); check("t3_lbr", b, 8'h5B);
        rx_byte(b); check("t3_rbr", b, 8'h5D);
        rx_byte(b); check("t3_dot", b, 8'h2E);
        rx_byte(b); check("t3_colon", b, 8'h3A);

        // Block of two words closed by CR LF (when enabled), then a fresh block
        do_reset();
        @(negedge clk);
        fork
            begin
                send_word(w1);
                send_word(w2);
                send_word(w3);
            end
        join_none
        rx_word(w1, "blk_w1");
        rx_word(w2, "blk_w2");
        rx_eol("blk_eol");
        rx_word(w3, "blk_w3");
        wait fork;

        // Reset during DATA of char 2 (data bit 1 of 'D' is 0)
        do_reset();
        send_word(w_rst);
        rx_byte(b); check("t5_c0", b, 8'h41);
        rx_byte(b); check("t5_c1", b, 8'h42);
        repeat (10) @(negedge clk);
        check("t5_pre_tx", tx, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_tx", tx, 1'b1);
        check("t5_ready", in_ready, 1'b1);
        check("t5_busy", busy, 1'b0);
        send_word(w_new);
        rx_word(w_new, "t5_new");

        // Reset and in_valid together: nothing accepted
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = w1;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rv_ready", in_ready, 1'b1);
        check("rv_busy", busy, 1'b0);
        check("rv_tx", tx, 1'b1);

        // in_valid held high with in_data changing every cycle: accepts at cycle 0 and cycle 201
        do_reset();
        @(negedge clk);
        fork
            begin
                in_valid = 1'b1;
                for (int c = 0; c < 300; c++) begin
                    in_data = pattern(c);
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
        join_none
        rx_word(pattern(0), "hold_w0");
        rx_word(pattern(201), "hold_w1");
        rx_eol("hold_eol");
        wait fork;
        cnt = 0;
        while (!in_ready && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        repeat (3) @(negedge clk);
        check("hold_no_extra", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
